band_peak_tracker: RTL and testbench
====================================

BAND_PEAK_TRACKER -- requirements
Module: band_peak_tracker

Interface
REQ-001 Parameter DATLEN, default 12, SHALL set the signed width of each FFT real/imaginary input word.
REQ-002 Parameter VLEN, default 32, SHALL set the FFT vector length, i.e. the number of bins per frame.
REQ-003 Parameter VLEN_LOG2, default 5, SHALL set the bin-index width and equal log2(VLEN).
REQ-004 Parameter NBANDS, default 2, SHALL set the number of independent frequency bands tracked.
REQ-005 Port clk, input, 1 bit, SHALL be the single clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-007 Port in_valid, input, 1 bit, SHALL qualify one FFT bin per cycle (FFT out_nd).
REQ-008 Port in_sof, input, 1 bit, SHALL mark bin 0 of a frame when in_valid is high.
REQ-009 Port in_re, input, DATLEN bits, SHALL carry the signed two's-complement real part.
REQ-010 Port in_im, input, DATLEN bits, SHALL carry the signed two's-complement imaginary part.
REQ-011 Port band_lo, input, NBANDS*VLEN_LOG2 bits, SHALL hold the inclusive low bin edge per band (band k at slice k).
REQ-012 Port band_hi, input, NBANDS*VLEN_LOG2 bits, SHALL hold the inclusive high bin edge per band.
REQ-013 Port peak_mag, output, NBANDS*(DATLEN+1) bits, SHALL hold the per-band peak magnitude of the last completed frame.
REQ-014 Port peak_bin, output, NBANDS*VLEN_LOG2 bits, SHALL hold the bin index of each band peak.
REQ-015 Port out_valid, output, 1 bit, SHALL indicate that peak_mag/peak_bin hold an unconsumed result.
REQ-016 Port out_ready, input, 1 bit, SHALL consume the result when high together with out_valid.
REQ-017 Port overrun, output, 1 bit, SHALL be a sticky flag set when a result is dropped.

Function
REQ-018 Magnitude SHALL be |re|+|im|, unsigned DATLEN+1 bits; |-2^(DATLEN-1)| = 2^(DATLEN-1) exactly, no saturation.
REQ-019 Bin counter SHALL load 0 on accepted in_sof, otherwise increment per accepted bin, and wrap VLEN-1 -> 0.
REQ-020 A frame SHALL complete on the accepted bin with index VLEN-1.
REQ-021 band_lo/band_hi SHALL be sampled on the accepted bin-0 beat and held constant for that frame.
REQ-022 Pipeline SHALL be two stages: stage 1 registers magnitude and bin index; stage 2 performs the per-band compare/update.
REQ-023 A bin SHALL update band k only if lo_k <= bin <= hi_k and mag > current peak (strict; ties keep the lower bin).
REQ-024 Per-band accumulators SHALL clear to mag 0 and bin lo_k at each frame start.
REQ-025 A band with lo_k > hi_k SHALL report mag 0 and bin lo_k.
REQ-026 On frame completion, results SHALL transfer to the output registers and out_valid SHALL rise 2 cycles after the last bin is accepted.
REQ-027 out_valid SHALL stay high, with outputs stable, until out_ready is high; it then clears the following cycle.
REQ-028 If a new frame completes while out_valid is high and out_ready is low, the new result SHALL overwrite the outputs and overrun SHALL set.
REQ-029 A completion and a consumption in the same cycle SHALL load the new result with out_valid high and SHALL NOT set overrun.
REQ-030 in_sof arriving mid-frame SHALL abandon the partial frame without producing output and restart at bin 0.
REQ-031 Idle cycles (in_valid low) SHALL NOT advance the counter or alter the accumulators.

Reset
REQ-032 rst SHALL clear out_valid, overrun, peak_mag, peak_bin, accumulators, the bin counter and the pipeline valid bits to 0.
REQ-033 rst asserted mid-frame SHALL discard the partial frame; the first result after reset requires a full frame starting with in_sof.
REQ-034 rst SHALL take priority over every other input in the same cycle.

Structure
REQ-035 The shared package SHALL hold default DATLEN/VLEN/VLEN_LOG2/NBANDS constants and the magnitude width expression DATLEN+1.
REQ-036 A single sub-module, cplx_abs_sum, SHALL compute |re|+|im| combinationally; one instance feeds pipeline stage 1.

Verification
REQ-037 Frame with bin 5 = (+100,-50) and all other bins 0, band0 = 3..7 -> peak_mag0 = 150, peak_bin0 = 5, out_valid high 2 cycles after bin 31.
REQ-038 Bins 4 and 6 both equal to (-2048,-2048) with DATLEN = 12 -> peak_mag = 4096, peak_bin = 4 (tie rule).
REQ-039 Two frames with out_ready held low -> second result visible, overrun = 1; a completion in the same cycle as an out_ready pulse -> overrun stays 0.
REQ-040 band1 lo = 9, hi = 2 -> peak_mag1 = 0, peak_bin1 = 9 each frame.
REQ-041 in_sof at bin 17, then a full frame -> exactly one out_valid; rst at bin 10 -> all outputs 0 and no result until the next full frame.

Source files
------------

// File: rtl/band_peak_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : band_peak_tracker_pkg
// Purpose  : Shared defaults and helpers for the band peak tracker.
//            Holds the default FFT word width, vector length, bin-index
//            width and band count, plus the magnitude width expression.
// Revision : 1.0  initial release
// ============================================================================
package band_peak_tracker_pkg;

    localparam int c_DATLEN    = 12;
    localparam int c_VLEN      = 32;
    localparam int c_VLEN_LOG2 = 5;
    localparam int c_NBANDS    = 2;

    // |re|+|im| of two DATLEN-bit signed words needs one extra bit:
    // the largest value is 2^(DATLEN-1) + 2^(DATLEN-1) = 2^DATLEN.
    function automatic int mag_width(input int datlen);
        return datlen + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cplx_abs_sum.sv
`default_nettype none
// ============================================================================
// Module   : cplx_abs_sum
// Purpose  : Combinational L1 magnitude |re| + |im| of a complex sample.
// Ports    : i_re, i_im - signed two's-complement DATLEN-bit parts
//            o_mag      - unsigned DATLEN+1-bit magnitude
// Revision : 1.0  initial release
// ============================================================================
module cplx_abs_sum
    import band_peak_tracker_pkg::*;
#(
    parameter int DATLEN = c_DATLEN
) (
    input  logic [DATLEN-1:0]            i_re,
    input  logic [DATLEN-1:0]            i_im,
    output logic [mag_width(DATLEN)-1:0] o_mag
);

    logic [DATLEN:0] w_re_ext;
    logic [DATLEN:0] w_im_ext;
    logic [DATLEN:0] w_re_abs;
    logic [DATLEN:0] w_im_abs;

    // Sign-extend by one bit before negating so the most negative input
    // maps to +2^(DATLEN-1) exactly instead of wrapping.
    assign w_re_ext = {i_re[DATLEN-1], i_re};
    assign w_im_ext = {i_im[DATLEN-1], i_im};
    assign w_re_abs = i_re[DATLEN-1] ? (~w_re_ext + 1'b1) : w_re_ext;
    assign w_im_abs = i_im[DATLEN-1] ? (~w_im_ext + 1'b1) : w_im_ext;

    assign o_mag = w_re_abs + w_im_abs;

endmodule
`default_nettype wire

// File: rtl/band_peak_tracker.sv
`default_nettype none
// ============================================================================
// Module   : band_peak_tracker
// Purpose  : Tracks the peak |re|+|im| magnitude and its bin index inside
//            NBANDS configurable bin ranges of a streamed FFT frame and
//            presents one result per completed frame with a valid/ready
//            handshake and a sticky overrun flag.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            in_valid, in_sof     - bin qualifier and frame-start marker
//            in_re, in_im         - signed FFT bin value
//            band_lo, band_hi     - inclusive bin edges, band k at slice k
//            peak_mag, peak_bin   - per-band result of last completed frame
//            out_valid, out_ready - result handshake
//            overrun              - sticky, a result was overwritten
// Revision : 1.0  initial release
// ============================================================================
module band_peak_tracker
    import band_peak_tracker_pkg::*;
#(
    parameter int DATLEN    = c_DATLEN,
    parameter int VLEN      = c_VLEN,
    parameter int VLEN_LOG2 = c_VLEN_LOG2,
    parameter int NBANDS    = c_NBANDS
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    input  logic                                in_sof,
    input  logic [DATLEN-1:0]                   in_re,
    input  logic [DATLEN-1:0]                   in_im,
    input  logic [NBANDS*VLEN_LOG2-1:0]         band_lo,
    input  logic [NBANDS*VLEN_LOG2-1:0]         band_hi,
    output logic [NBANDS*mag_width(DATLEN)-1:0] peak_mag,
    output logic [NBANDS*VLEN_LOG2-1:0]         peak_bin,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                overrun
);

    localparam int                   c_MAGLEN   = mag_width(DATLEN);
    localparam logic [VLEN_LOG2-1:0] c_LAST_BIN = VLEN_LOG2'(VLEN - 1);

    // ---------------------------------------------------------------- input
    logic                          r_in_frame;
    logic [VLEN_LOG2-1:0]          r_cnt;
    logic                          w_accept;
    logic [VLEN_LOG2-1:0]          w_bin;
    logic [c_MAGLEN-1:0]           w_mag;

    // Bins are only taken once a frame has been opened by in_sof, so after
    // reset nothing is produced until a full frame starting at bin 0.
    assign w_accept = in_valid && (in_sof || r_in_frame);
    assign w_bin    = in_sof ? '0 : r_cnt;

    cplx_abs_sum #(
        .DATLEN (DATLEN)
    ) u_abs (
        .i_re   (in_re),
        .i_im   (in_im),
        .o_mag  (w_mag)
    );

    // -------------------------------------------------------------- stage 1
    logic                          r_s1_valid;
    logic [c_MAGLEN-1:0]           r_s1_mag;
    logic [VLEN_LOG2-1:0]          r_s1_bin;
    logic [NBANDS*VLEN_LOG2-1:0]   r_lo;
    logic [NBANDS*VLEN_LOG2-1:0]   r_hi;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_frame <= 1'b0;
            r_cnt      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_mag   <= '0;
            r_s1_bin   <= '0;
            r_lo       <= '0;
            r_hi       <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_in_frame <= 1'b1;
                r_cnt      <= (w_bin == c_LAST_BIN) ? '0 : w_bin + 1'b1;
                r_s1_mag   <= w_mag;
                r_s1_bin   <= w_bin;
                // Edges are frozen at bin 0; stage 2 of the previous
                // frame's last bin still reads the old copy this cycle.
                if (w_bin == '0) begin
                    r_lo <= band_lo;
                    r_hi <= band_hi;
                end
            end
        end
    end

    // -------------------------------------------------------------- stage 2
    logic                          w_s1_first;
    logic                          w_done;
    logic [NBANDS*c_MAGLEN-1:0]    r_acc_mag;
    logic [NBANDS*VLEN_LOG2-1:0]   r_acc_bin;
    logic [NBANDS*c_MAGLEN-1:0]    w_upd_mag;
    logic [NBANDS*VLEN_LOG2-1:0]   w_upd_bin;

    assign w_s1_first = (r_s1_bin == '0);
    assign w_done     = r_s1_valid && (r_s1_bin == c_LAST_BIN);

    generate
        for (genvar k = 0; k < NBANDS; k++) begin : g_band
            logic [VLEN_LOG2-1:0] w_lo;
            logic [VLEN_LOG2-1:0] w_hi;
            logic [c_MAGLEN-1:0]  w_base_mag;
            logic [VLEN_LOG2-1:0] w_base_bin;
            logic                 w_hit;

            assign w_lo = r_lo[k*VLEN_LOG2 +: VLEN_LOG2];
            assign w_hi = r_hi[k*VLEN_LOG2 +: VLEN_LOG2];

            // Bin 0 compares against the cleared state (0, lo) rather than
            // whatever the previous or abandoned frame left behind.
            assign w_base_mag = w_s1_first ? '0   : r_acc_mag[k*c_MAGLEN +: c_MAGLEN];
            assign w_base_bin = w_s1_first ? w_lo : r_acc_bin[k*VLEN_LOG2 +: VLEN_LOG2];

            // Strict greater-than keeps the earliest (lowest) bin on ties.
            assign w_hit = (r_s1_bin >= w_lo) && (r_s1_bin <= w_hi) &&
                           (r_s1_mag > w_base_mag);

            assign w_upd_mag[k*c_MAGLEN +: c_MAGLEN]   = w_hit ? r_s1_mag : w_base_mag;
            assign w_upd_bin[k*VLEN_LOG2 +: VLEN_LOG2] = w_hit ? r_s1_bin : w_base_bin;
        end
    endgenerate

    // --------------------------------------------------------------- output
    logic [NBANDS*c_MAGLEN-1:0]    r_peak_mag;
    logic [NBANDS*VLEN_LOG2-1:0]   r_peak_bin;
    logic                          r_out_valid;
    logic                          r_overrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_mag   <= '0;
            r_acc_bin   <= '0;
            r_peak_mag  <= '0;
            r_peak_bin  <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (r_s1_valid) begin
                r_acc_mag <= w_upd_mag;
                r_acc_bin <= w_upd_bin;
            end
            if (w_done) begin
                // A simultaneous consume frees the slot, so only an
                // unconsumed result being replaced counts as overrun.
                r_peak_mag  <= w_upd_mag;
                r_peak_bin  <= w_upd_bin;
                r_out_valid <= 1'b1;
                if (r_out_valid && !out_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign peak_mag  = r_peak_mag;
    assign peak_bin  = r_peak_bin;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_band_peak_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_band_peak_tracker
// Purpose  : Self-checking bench for band_peak_tracker. A frame-level model
//            computes expected band peaks from buffered magnitudes; every
//            cycle the DUT outputs are compared against it, and directed
//            scenarios add hand-computed literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_band_peak_tracker;

    localparam int DATLEN    = 12;
    localparam int VLEN      = 32;
    localparam int VLEN_LOG2 = 5;
    localparam int NBANDS    = 2;
    localparam int MAGLEN    = DATLEN + 1;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         in_valid;
    logic                         in_sof;
    logic [DATLEN-1:0]            in_re;
    logic [DATLEN-1:0]            in_im;
    logic [NBANDS*VLEN_LOG2-1:0]  band_lo;
    logic [NBANDS*VLEN_LOG2-1:0]  band_hi;
    logic [NBANDS*MAGLEN-1:0]     peak_mag;
    logic [NBANDS*VLEN_LOG2-1:0]  peak_bin;
    logic                         out_valid;
    logic                         out_ready;
    logic                         overrun;

    logic [VLEN_LOG2-1:0]         blo [NBANDS];
    logic [VLEN_LOG2-1:0]         bhi [NBANDS];

    assign band_lo = {blo[1], blo[0]};
    assign band_hi = {bhi[1], bhi[0]};

    band_peak_tracker #(
        .DATLEN    (DATLEN),
        .VLEN      (VLEN),
        .VLEN_LOG2 (VLEN_LOG2),
        .NBANDS    (NBANDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_re     (in_re),
        .in_im     (in_im),
        .band_lo   (band_lo),
        .band_hi   (band_hi),
        .peak_mag  (peak_mag),
        .peak_bin  (peak_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [MAGLEN-1:0] pm(input int k);
        return peak_mag[k*MAGLEN +: MAGLEN];
    endfunction

    function automatic logic [VLEN_LOG2-1:0] pb(input int k);
        return peak_bin[k*VLEN_LOG2 +: VLEN_LOG2];
    endfunction

    // ------------------------------------------------------------ model
    int m_mag [VLEN];
    int m_lo [NBANDS];
    int m_hi [NBANDS];
    int m_cnt;
    int m_idx;
    bit m_in_frame;
    bit m_pend;
    int m_pend_mag [NBANDS];
    int m_pend_bin [NBANDS];
    bit e_valid;
    bit e_ovr;
    int e_mag [NBANDS];
    int e_bin [NBANDS];

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_in_frame = 0; m_pend = 0; e_valid = 0; e_ovr = 0;
            for (int k = 0; k < NBANDS; k++) begin
                e_mag[k] = 0; e_bin[k] = 0;
            end
        end else begin
            // A result found at the previous edge becomes visible now.
            if (m_pend) begin
                if (e_valid && !out_ready) e_ovr = 1;
                e_valid = 1;
                e_mag   = m_pend_mag;
                e_bin   = m_pend_bin;
            end else if (e_valid && out_ready) begin
                e_valid = 0;
            end
            m_pend = 0;
            if (in_valid && (in_sof || m_in_frame)) begin
                m_idx      = in_sof ? 0 : m_cnt;
                m_in_frame = 1;
                if (m_idx == 0) begin
                    for (int k = 0; k < NBANDS; k++) begin
                        m_lo[k] = int'(blo[k]);
                        m_hi[k] = int'(bhi[k]);
                    end
                end
                m_mag[m_idx] = iabs(int'($signed(in_re))) + iabs(int'($signed(in_im)));
                m_cnt = (m_idx + 1) % VLEN;
                if (m_idx == VLEN - 1) begin
                    for (int k = 0; k < NBANDS; k++) begin
                        m_pend_mag[k] = 0;
                        m_pend_bin[k] = m_lo[k];
                        for (int b = m_lo[k]; b <= m_hi[k]; b++) begin
                            if (m_mag[b] > m_pend_mag[k]) begin
                                m_pend_mag[k] = m_mag[b];
                                m_pend_bin[k] = b;
                            end
                        end
                    end
                    m_pend = 1;
                end
            end
        end
    end

    // ---------------------------------------------------------- compare
    bit cmp_en = 0;
    bit prev_valid = 0;
    int valid_rises = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_out_valid", out_valid, e_valid);
            check("cyc_overrun", overrun, e_ovr);
            for (int k = 0; k < NBANDS; k++) begin
                check("cyc_peak_mag", pm(k), e_mag[k]);
                check("cyc_peak_bin", pb(k), e_bin[k]);
            end
            if (out_valid && !prev_valid) valid_rises++;
            prev_valid = out_valid;
        end
    end

    // ------------------------------------------------------- stimulus
    int fre [VLEN];
    int fim [VLEN];

    task automatic clear_frame();
        for (int i = 0; i < VLEN; i++) begin
            fre[i] = 0; fim[i] = 0;
        end
    endtask

    task automatic beat(input bit sof, input int re, input int im);
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = sof;
        in_re    = re[DATLEN-1:0];
        in_im    = im[DATLEN-1:0];
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = 1'b0;
        end
    endtask

    task automatic send(input bit sof, input int first, input int last, input bit gaps);
        for (int i = first; i <= last; i++) begin
            beat(sof && (i == first), fre[i], fim[i]);
            if (gaps && (i % 7 == 3)) idle(2);
        end
    endtask

    task automatic consume();
        @(negedge clk);
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    int rises0;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_re = '0; in_im = '0;
        out_ready = 1'b0;
        blo[0] = 5'd3; bhi[0] = 5'd7;
        blo[1] = 5'd9; bhi[1] = 5'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1;

        check("rst_out_valid", out_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_peak_mag", peak_mag, 0);
        check("rst_peak_bin", peak_bin, 0);

        // Single in-band peak and result latency.
        clear_frame();
        fre[5] = 100; fim[5] = -50;
        send(1, 0, 31, 0);
        idle(1);
        check("lat_not_yet", out_valid, 0);
        idle(1);
        check("lat_valid", out_valid, 1);
        check("t1_mag0", pm(0), 150);
        check("t1_bin0", pb(0), 5);
        check("inv_mag1", pm(1), 0);
        check("inv_bin1", pb(1), 9);
        consume();

        // Most negative words and the tie rule, with idle gaps.
        clear_frame();
        fre[4] = -2048; fim[4] = -2048;
        fre[6] = -2048; fim[6] = -2048;
        send(1, 0, 31, 1);
        idle(2);
        check("tie_mag0", pm(0), 4096);
        check("tie_bin0", pb(0), 4);
        check("tie_bin1", pb(1), 9);
        consume();

        // Two unconsumed frames overrun.
        blo[1] = 5'd8; bhi[1] = 5'd20;
        clear_frame(); fre[10] = 7;
        send(1, 0, 31, 0);
        idle(2);
        clear_frame(); fim[15] = -33;
        send(1, 0, 31, 0);
        idle(2);
        check("ovr_set", overrun, 1);
        check("ovr_mag1", pm(1), 33);
        check("ovr_bin1", pb(1), 15);
        consume();
        check("ovr_consumed", out_valid, 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("ovr_cleared", overrun, 0);

        // Completion coincident with consumption.
        clear_frame(); fre[12] = 9;
        send(1, 0, 31, 0);
        idle(2);
        clear_frame(); fim[20] = 500;
        send(1, 0, 31, 0);
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        check("same_valid", out_valid, 1);
        check("same_ovr", overrun, 0);
        check("same_mag1", pm(1), 500);
        check("same_bin1", pb(1), 20);
        consume();

        // Edges change mid-frame; the frame keeps its bin-0 copy.
        for (int i = 0; i < VLEN; i++) begin
            fre[i] = int'($urandom_range(4095)) - 2048;
            fim[i] = int'($urandom_range(4095)) - 2048;
        end
        send(1, 0, 4, 0);
        blo[0] = 5'd0; bhi[0] = 5'd31;
        send(0, 5, 31, 0);
        idle(2);
        consume();
        // Frame reached by wrap-around without in_sof, wide band0.
        for (int i = 0; i < VLEN; i++) begin
            fre[i] = int'($urandom_range(4095)) - 2048;
            fim[i] = int'($urandom_range(4095)) - 2048;
        end
        send(0, 0, 31, 0);
        idle(2);
        check("wrap_valid", out_valid, 1);
        consume();
        blo[0] = 5'd3; bhi[0] = 5'd7;

        // in_sof mid-frame abandons the partial frame.
        rises0 = valid_rises;
        clear_frame(); fre[6] = 77;
        send(1, 0, 16, 0);
        send(1, 0, 31, 0);
        idle(4);
        check("sof_one_result", valid_rises - rises0, 1);
        check("sof_mag0", pm(0), 77);
        consume();

        // Reset mid-frame, asserted alongside an in_sof beat.
        send(1, 0, 9, 0);
        beat(1, 1000, 1000);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_mag", peak_mag, 0);
        check("mid_rst_bin", peak_bin, 0);
        send(0, 0, 31, 0);
        idle(3);
        check("no_sof_no_result", out_valid, 0);
        send(1, 0, 31, 0);
        idle(2);
        check("post_rst_result", out_valid, 1);
        check("post_rst_mag0", pm(0), 77);
        consume();
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
